multiport_regfile: RTL and testbench
====================================

// Module: multiport_regfile
// PURPOSE
//  Parametrised register file for the processor datapath: N registered read ports, two write ports,
//  same-cycle write-to-read bypass, optional hardwired-zero register 0 and a per-register busy
//  scoreboard. Sits between decode (reads and reservations) and writeback (writes).
// PARAMETERS
//  WIDTH       32  data width of every register
//  COUNT       8   number of registers; ADDR_W = clog2(COUNT), minimum 1
//  READ_PORTS  2   number of independent read ports, 1..4
//  ZERO_REG    1   1: register 0 always reads 0 and ignores writes; 0: register 0 is ordinary
// PORTS
//  clk            in   1                    single clock; all state updates on posedge
//  rst            in   1                    synchronous, active-high reset
//  read_enable    in   READ_PORTS           per-port read strobe
//  read_addr      in   READ_PORTS*ADDR_W    packed read addresses; port p = [p*ADDR_W +: ADDR_W]
//  read_data      out  READ_PORTS*WIDTH     packed registered read data
//  read_valid     out  READ_PORTS           1 for the cycle after a sampled read_enable
//  read_busy      out  READ_PORTS           registered busy bit of the addressed register
//  write_enable   in   2                    write strobe for ports 0 and 1
//  write_addr0/1  in   ADDR_W               write addresses
//  write_data0/1  in   WIDTH                write data
//  reserve_enable in   1                    mark reserve_addr busy (pending producer)
//  reserve_addr   in   ADDR_W               register to reserve
//  busy_vector    out  COUNT                live scoreboard, bit r = register r busy
// BEHAVIOUR
//  Reset (rst=1 at posedge): all registers, busy_vector, read_data, read_valid, read_busy <= 0.
//   rst has priority over every other input in that cycle; operations in flight are discarded.
//  Write: on posedge with write_enable[k]=1, reg[write_addrk] <= write_datak.
//   Both ports, same address: port 1 wins. Different addresses: both commit.
//   ZERO_REG=1 and address 0: write dropped; busy bit 0 never sets.
//  Read latency 1: read_enable[p] sampled at posedge N -> read_data/read_valid/read_busy valid
//   after posedge N. read_enable[p]=0: read_data[p] holds its last value, read_valid[p] <= 0,
//   read_busy[p] holds. Outputs never tri-state.
//  Bypass: read address equal to an active write address in the same cycle returns the write
//   data (port 1 over port 0), not the stale stored value. ZERO_REG=1 and address 0 -> 0.
//  Scoreboard: reserve_enable sets busy[reserve_addr]; any write_enable[k] clears
//   busy[write_addrk]. Reserve and write to the same address in one cycle: busy stays set
//   (new producer wins). read_busy reflects the value busy will hold after that edge.
//  Out-of-range addresses (COUNT not a power of 2): reads return 0, writes/reserves dropped.
//  All read ports fully independent; identical addresses on several ports permitted.
// STRUCTURE
//  Shared header regfile_defs.vh: clog2 function, ZERO_REG default, packed-port slice macros;
//   reused by the decode and hazard units.
//  Sub-module regfile_read_port (one per port via generate): address decode, bypass mux,
//   zero/out-of-range masking and output registers. Top holds storage, write logic and scoreboard.
// TESTING
//  Reset: write all regs, pulse rst -> every read returns 0, busy_vector=0, read_valid=0.
//  Basic: write r3=0xDEADBEEF; next cycle read port0 r3 -> read_data0=0xDEADBEEF one cycle later,
//   read_valid0=1.
//  Bypass/collision: same cycle write0 r5=0x11, write1 r5=0x22, read r5 on both ports
//   -> both read 0x22; later read of r5 also 0x22.
//  Zero reg: ZERO_REG=1, write r0=0xFFFF_FFFF, read r0 -> 0; with ZERO_REG=0 -> 0xFFFF_FFFF.
//  Scoreboard: reserve r2 -> busy_vector[2]=1; reserve r2 and write r2 same cycle -> stays 1;
//   write r2 alone -> 0; read r2 while reserved -> read_busy=1.
//  Hold/reset mid-op: read r4 (=0x7), deassert read_enable -> read_data holds 0x7, read_valid=0;
//   assert rst together with a write -> write discarded, all outputs 0.

Source files
------------

// File: rtl/multiport_regfile_pkg.sv
// ---------------------------------------------------------------------------
// multiport_regfile_pkg
//   Shared definitions for the multi-ported register file. Other datapath
//   blocks that build packed read/write port buses should import this too,
//   so that they size their address fields the same way.
//
//   Contents:
//     DEFAULT_*    default parameter values for the register file
//     WRITE_PORTS  number of writeback ports (fixed at two)
//     addrWidth()  address width needed for a register count, minimum 1
// ---------------------------------------------------------------------------
package multiport_regfile_pkg;

    localparam int DEFAULT_WIDTH      = 32;
    localparam int DEFAULT_COUNT      = 8;
    localparam int DEFAULT_READ_PORTS = 2;
    localparam int DEFAULT_ZERO_REG   = 1;
    localparam int WRITE_PORTS        = 2;

    // Ceiling log2 with a floor of one bit, so a single-register file still
    // has a well-formed address field.
    function automatic int addrWidth(input int count);
        int w;
        w = 1;
        while ((1 << w) < count) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/multiport_regfile_read_port.sv
// ---------------------------------------------------------------------------
// multiport_regfile_read_port
//   One registered read port of the register file. Decodes its address
//   against the storage array, forwards same-cycle write data over the
//   stored value, forces zero for register 0 (when hardwired) and for
//   addresses past the end of the file, then registers the result.
//
//   Ports:
//     clk, rst          clock and synchronous active-high reset
//     read_enable_i     read strobe for this port
//     read_addr_i       register address to read
//     regs_i            whole storage array from the top
//     busy_next_i       scoreboard value that will be held after this edge
//     write_enable_i    write strobes of both write ports
//     write_addr0/1_i   write addresses
//     write_data0/1_i   write data
//     read_data_o       registered read data (holds when not enabled)
//     read_valid_o      high for the cycle after an enabled read
//     read_busy_o       registered busy bit of the addressed register
// ---------------------------------------------------------------------------
module multiport_regfile_read_port
    import multiport_regfile_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int COUNT    = DEFAULT_COUNT,
    parameter int ADDR_W   = addrWidth(DEFAULT_COUNT),
    parameter int ZERO_REG = DEFAULT_ZERO_REG
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         read_enable_i,
    input  logic [ADDR_W-1:0]            read_addr_i,
    input  logic [COUNT-1:0][WIDTH-1:0]  regs_i,
    input  logic [COUNT-1:0]             busy_next_i,
    input  logic [WRITE_PORTS-1:0]       write_enable_i,
    input  logic [ADDR_W-1:0]            write_addr0_i,
    input  logic [ADDR_W-1:0]            write_addr1_i,
    input  logic [WIDTH-1:0]             write_data0_i,
    input  logic [WIDTH-1:0]             write_data1_i,
    output logic [WIDTH-1:0]             read_data_o,
    output logic                         read_valid_o,
    output logic                         read_busy_o
);

    logic             addrHit;
    logic [WIDTH-1:0] storedValue;
    logic [WIDTH-1:0] readValue;
    logic             busyValue;
    logic [WIDTH-1:0] readData_d, readData_q;
    logic             readBusy_d, readBusy_q;
    logic             readValid_q;

    // Select the stored value and busy bit for the addressed register. The
    // decode walks only the registers that exist, so an address beyond
    // COUNT never hits and is masked to zero below. Write data then
    // overrides the stored value when a write lands on the same address
    // this cycle, port 1 taking precedence to match the storage update.
    always_comb begin
        addrHit     = 1'b0;
        storedValue = '0;
        busyValue   = 1'b0;
        for (int r = 0; r < COUNT; r++) begin
            if (read_addr_i == ADDR_W'(r)) begin
                addrHit     = 1'b1;
                storedValue = regs_i[r];
                busyValue   = busy_next_i[r];
            end
        end

        readValue = storedValue;
        if (write_enable_i[1] && (write_addr1_i == read_addr_i)) begin
            readValue = write_data1_i;
        end else if (write_enable_i[0] && (write_addr0_i == read_addr_i)) begin
            readValue = write_data0_i;
        end

        if (!addrHit || ((ZERO_REG != 0) && (read_addr_i == '0))) begin
            readValue = '0;
        end

        readData_d = readData_q;
        readBusy_d = readBusy_q;
        if (read_enable_i) begin
            readData_d = readValue;
            readBusy_d = busyValue;
        end
    end

    // Output registers. Data and busy hold their last value between reads
    // so consumers can keep sampling them; valid is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            readData_q  <= '0;
            readBusy_q  <= 1'b0;
            readValid_q <= 1'b0;
        end else begin
            readData_q  <= readData_d;
            readBusy_q  <= readBusy_d;
            readValid_q <= read_enable_i;
        end
    end

    assign read_data_o  = readData_q;
    assign read_valid_o = readValid_q;
    assign read_busy_o  = readBusy_q;

endmodule

// File: rtl/multiport_regfile.sv
// ---------------------------------------------------------------------------
// multiport_regfile
//   Register file for the processor datapath: READ_PORTS registered read
//   ports with write-to-read bypass, two write ports, an optional hardwired
//   zero register and a busy scoreboard for pending producers. Decode reads
//   and reserves registers, writeback writes them and clears their busy bit.
//
//   Ports:
//     clk, rst         clock and synchronous active-high reset
//     read_enable      per-port read strobe
//     read_addr        packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//     read_data        packed registered read data, port p at [p*WIDTH +: WIDTH]
//     read_valid       per-port pulse the cycle after an enabled read
//     read_busy        per-port registered busy bit of the addressed register
//     write_enable     strobes for write ports 0 and 1
//     write_addr0/1    write addresses
//     write_data0/1    write data
//     reserve_enable   mark reserve_addr as having a pending producer
//     reserve_addr     register to reserve
//     busy_vector      live scoreboard, bit r set while register r is busy
// ---------------------------------------------------------------------------
module multiport_regfile
    import multiport_regfile_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int COUNT      = DEFAULT_COUNT,
    parameter int READ_PORTS = DEFAULT_READ_PORTS,
    parameter int ZERO_REG   = DEFAULT_ZERO_REG,
    localparam int ADDR_W    = addrWidth(COUNT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [READ_PORTS-1:0]        read_enable,
    input  logic [READ_PORTS*ADDR_W-1:0] read_addr,
    output logic [READ_PORTS*WIDTH-1:0]  read_data,
    output logic [READ_PORTS-1:0]        read_valid,
    output logic [READ_PORTS-1:0]        read_busy,
    input  logic [WRITE_PORTS-1:0]       write_enable,
    input  logic [ADDR_W-1:0]            write_addr0,
    input  logic [ADDR_W-1:0]            write_addr1,
    input  logic [WIDTH-1:0]             write_data0,
    input  logic [WIDTH-1:0]             write_data1,
    input  logic                         reserve_enable,
    input  logic [ADDR_W-1:0]            reserve_addr,
    output logic [COUNT-1:0]             busy_vector
);

    logic [COUNT-1:0][WIDTH-1:0] regs_d, regs_q;
    logic [COUNT-1:0]            busy_d, busy_q;

    // Next state of storage and scoreboard. Only existing registers are
    // visited, so out-of-range writes and reserves fall away naturally, and
    // register 0 is skipped entirely when hardwired to zero. Port 1 is
    // applied after port 0 so it wins a same-address collision; the reserve
    // is applied last so a new producer keeps the register busy even when
    // the old producer writes back in the same cycle.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int r = 0; r < COUNT; r++) begin
            if (!((ZERO_REG != 0) && (r == 0))) begin
                if (write_enable[0] && (write_addr0 == ADDR_W'(r))) begin
                    regs_d[r] = write_data0;
                    busy_d[r] = 1'b0;
                end
                if (write_enable[1] && (write_addr1 == ADDR_W'(r))) begin
                    regs_d[r] = write_data1;
                    busy_d[r] = 1'b0;
                end
                if (reserve_enable && (reserve_addr == ADDR_W'(r))) begin
                    busy_d[r] = 1'b1;
                end
            end
        end
    end

    // Storage and scoreboard registers; reset clears both and discards any
    // write or reserve presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vector = busy_q;

    // One independent read port per slice of the packed buses. Each port
    // sees the next-state scoreboard so read_busy matches what busy_vector
    // will show after the same edge.
    for (genvar p = 0; p < READ_PORTS; p++) begin : g_readPort
        multiport_regfile_read_port #(
            .WIDTH    (WIDTH),
            .COUNT    (COUNT),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_readPort (
            .clk            (clk),
            .rst            (rst),
            .read_enable_i  (read_enable[p]),
            .read_addr_i    (read_addr[p*ADDR_W +: ADDR_W]),
            .regs_i         (regs_q),
            .busy_next_i    (busy_d),
            .write_enable_i (write_enable),
            .write_addr0_i  (write_addr0),
            .write_addr1_i  (write_addr1),
            .write_data0_i  (write_data0),
            .write_data1_i  (write_data1),
            .read_data_o    (read_data[p*WIDTH +: WIDTH]),
            .read_valid_o   (read_valid[p]),
            .read_busy_o    (read_busy[p])
        );
    end

endmodule

// File: tb/tb_multiport_regfile.sv
// ---------------------------------------------------------------------------
// tb_multiport_regfile
//   Directed bench for multiport_regfile. Two instances share all inputs:
//   dutA uses the defaults (8 registers, hardwired zero register) and dutB
//   has 6 registers with an ordinary register 0, so addresses 6 and 7 are
//   out of range for it. Expected values are worked out by hand per step.
// ---------------------------------------------------------------------------
module tb_multiport_regfile;

    logic        clk;
    logic        rst;
    logic [1:0]  readEnable;
    logic [5:0]  readAddr;
    logic [1:0]  writeEnable;
    logic [2:0]  writeAddr0;
    logic [2:0]  writeAddr1;
    logic [31:0] writeData0;
    logic [31:0] writeData1;
    logic        reserveEnable;
    logic [2:0]  reserveAddr;

    logic [63:0] readDataA, readDataB;
    logic [1:0]  readValidA, readValidB;
    logic [1:0]  readBusyA, readBusyB;
    logic [7:0]  busyVectorA;
    logic [5:0]  busyVectorB;

    int checkCount = 0;
    int errorCount = 0;

    multiport_regfile dutA (
        .clk            (clk),
        .rst            (rst),
        .read_enable    (readEnable),
        .read_addr      (readAddr),
        .read_data      (readDataA),
        .read_valid     (readValidA),
        .read_busy      (readBusyA),
        .write_enable   (writeEnable),
        .write_addr0    (writeAddr0),
        .write_addr1    (writeAddr1),
        .write_data0    (writeData0),
        .write_data1    (writeData1),
        .reserve_enable (reserveEnable),
        .reserve_addr   (reserveAddr),
        .busy_vector    (busyVectorA)
    );

    multiport_regfile #(
        .COUNT    (6),
        .ZERO_REG (0)
    ) dutB (
        .clk            (clk),
        .rst            (rst),
        .read_enable    (readEnable),
        .read_addr      (readAddr),
        .read_data      (readDataB),
        .read_valid     (readValidB),
        .read_busy      (readBusyB),
        .write_enable   (writeEnable),
        .write_addr0    (writeAddr0),
        .write_addr1    (writeAddr1),
        .write_data0    (writeData0),
        .write_data1    (writeData1),
        .reserve_enable (reserveEnable),
        .reserve_addr   (reserveAddr),
        .busy_vector    (busyVectorB)
    );

    // Free-running 10-unit clock, rising at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the rising edge take them, and return
    // 1 unit later so outputs are sampled well away from the edge.
    task automatic applyStimulus(
        input logic        rstIn,
        input logic [1:0]  we,
        input logic [2:0]  wa0,
        input logic [31:0] wd0,
        input logic [2:0]  wa1,
        input logic [31:0] wd1,
        input logic [1:0]  re,
        input logic [2:0]  ra0,
        input logic [2:0]  ra1,
        input logic        resEn,
        input logic [2:0]  resAddr
    );
        rst           = rstIn;
        writeEnable   = we;
        writeAddr0    = wa0;
        writeData0    = wd0;
        writeAddr1    = wa1;
        writeData1    = wd1;
        readEnable    = re;
        readAddr      = {ra1, ra0};
        reserveEnable = resEn;
        reserveAddr   = resAddr;
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(
        input string       tag,
        input logic [63:0] observed,
        input logic [63:0] expected
    );
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        // Power-up reset with every input quiet.
        applyStimulus(1'b1, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0);
        applyStimulus(1'b1, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0);
        checkOutput("initDataA",  64'(readDataA),   64'h0);
        checkOutput("initValidA", 64'(readValidA),  64'h0);
        checkOutput("initBusyA",  64'(busyVectorA), 64'h0);

        // Fill every address with 0x100+i; dutB drops 6 and 7, dutA drops 0.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 2'b01, 3'(i), 32'h100 + 32'(i), 3'd0, 32'h0,
                          2'b00, 3'd0, 3'd0, 1'b0, 3'd0);
        end

        // Read r5 on both ports.
        applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 2'b11, 3'd5, 3'd5, 1'b0, 3'd0);
        checkOutput("fillR5DataA",  64'(readDataA),  {32'h105, 32'h105});
        checkOutput("fillR5DataB",  64'(readDataB),  {32'h105, 32'h105});
        checkOutput("fillR5ValidA", 64'(readValidA), 64'h3);

        // Port 0 reads r0, port 1 reads r7 (out of range for dutB).
        applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 2'b11, 3'd0, 3'd7, 1'b0, 3'd0);
        checkOutput("r0r7DataA", 64'(readDataA), {32'h107, 32'h0});
        checkOutput("r0r7DataB", 64'(readDataB), {32'h0, 32'h100});

        // Reset together with a write and a read: everything discarded.
        applyStimulus(1'b1, 2'b01, 3'd1, 32'hAAAA, 3'd0, 32'h0, 2'b11, 3'd1, 3'd1, 1'b1, 3'd1);
        checkOutput("rstDataA",  64'(readDataA),   64'h0);
        checkOutput("rstDataB",  64'(readDataB),   64'h0);
        checkOutput("rstValidA", 64'(readValidA),  64'h0);
        checkOutput("rstBusyA",  64'(busyVectorA), 64'h0);
        checkOutput("rstBusyB",  64'(busyVectorB), 64'h0);
        applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 2'b11, 3'd1, 3'd5, 1'b0, 3'd0);
        checkOutput("postRstDataA",  64'(readDataA),  64'h0);
        checkOutput("postRstDataB",  64'(readDataB),  64'h0);
        checkOutput("postRstValidB", 64'(readValidB), 64'h3);

        // Basic write then read with one-cycle latency.
        applyStimulus(1'b0, 2'b01, 3'd3, 32'hDEADBEEF, 3'd0, 32'h0, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0);
        checkOutput("wrOnlyValidA", 64'(readValidA), 64'h0);
        applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 2'b01, 3'd3, 3'd0, 1'b0, 3'd0);
        checkOutput("basicDataA",  64'(readDataA),  {32'h0, 32'hDEADBEEF});
        checkOutput("basicDataB",  64'(readDataB),  {32'h0, 32'hDEADBEEF});
        checkOutput("basicValidA", 64'(readValidA), 64'h1);

        // Both write ports hit r5 while both read ports read r5.
        applyStimulus(1'b0, 2'b11, 3'd5, 32'h11, 3'd5, 32'h22, 2'b11, 3'd5, 3'd5, 1'b0, 3'd0);
        checkOutput("collideDataA", 64'(readDataA), {32'h22, 32'h22});
        checkOutput("collideDataB", 64'(readDataB), {32'h22, 32'h22});
        applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 2'b01, 3'd5, 3'd0, 1'b0, 3'd0);
        checkOutput("collideLaterA",  64'(readDataA),  {32'h22, 32'h22});
        checkOutput("collideValidA",  64'(readValidA), 64'h1);

        // Write all-ones to r0 and read it in the same cycle, then again.
        applyStimulus(1'b0, 2'b01, 3'd0, 32'hFFFFFFFF, 3'd0, 32'h0, 2'b01, 3'd0, 3'd0, 1'b0, 3'd0);
        checkOutput("zeroBypassA", 64'(readDataA), {32'h22, 32'h0});
        checkOutput("zeroBypassB", 64'(readDataB), {32'h22, 32'hFFFFFFFF});
        applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 2'b01, 3'd0, 3'd0, 1'b0, 3'd0);
        checkOutput("zeroStoredA", 64'(readDataA), {32'h22, 32'h0});
        checkOutput("zeroStoredB", 64'(readDataB), {32'h22, 32'hFFFFFFFF});

        // Reserve r2 while port 0 reads it.
        applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 2'b01, 3'd2, 3'd0, 1'b1, 3'd2);
        checkOutput("resBusyVecA", 64'(busyVectorA), 64'h04);
        checkOutput("resBusyVecB", 64'(busyVectorB), 64'h04);
        checkOutput("resReadBusyA", 64'(readBusyA),  64'h1);

        // Reserve and write r2 together; port 1 reads r2.
        applyStimulus(1'b0, 2'b01, 3'd2, 32'h55, 3'd0, 32'h0, 2'b10, 3'd0, 3'd2, 1'b1, 3'd2);
        checkOutput("resWrBusyVecA", 64'(busyVectorA), 64'h04);
        checkOutput("resWrReadBusyA", 64'(readBusyA),  64'h3);
        checkOutput("resWrDataA",    64'(readDataA),   {32'h55, 32'h0});

        // Write r2 alone through port 1; port 0 reads it.
        applyStimulus(1'b0, 2'b10, 3'd0, 32'h0, 3'd2, 32'h66, 2'b01, 3'd2, 3'd0, 1'b0, 3'd0);
        checkOutput("clrBusyVecA",  64'(busyVectorA), 64'h0);
        checkOutput("clrBusyVecB",  64'(busyVectorB), 64'h0);
        checkOutput("clrReadBusyA", 64'(readBusyA),   64'h2);
        checkOutput("clrDataB",     64'(readDataB),   {32'h55, 32'h66});

        // Reserve r0: never busy on the hardwired-zero file.
        applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 2'b00, 3'd0, 3'd0, 1'b1, 3'd0);
        checkOutput("resR0BusyA", 64'(busyVectorA), 64'h0);
        checkOutput("resR0BusyB", 64'(busyVectorB), 64'h01);

        // Reserve r7: out of range for dutB, so its scoreboard is unchanged.
        applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 2'b00, 3'd0, 3'd0, 1'b1, 3'd7);
        checkOutput("resR7BusyA", 64'(busyVectorA), 64'h80);
        checkOutput("resR7BusyB", 64'(busyVectorB), 64'h01);

        // Hold behaviour: read r4 = 7, then idle.
        applyStimulus(1'b0, 2'b01, 3'd4, 32'h7, 3'd0, 32'h0, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0);
        applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 2'b01, 3'd4, 3'd0, 1'b0, 3'd0);
        checkOutput("holdReadA",  64'(readDataA),  {32'h55, 32'h7});
        checkOutput("holdValid1", 64'(readValidA), 64'h1);
        applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0);
        checkOutput("holdDataA",  64'(readDataA),  {32'h55, 32'h7});
        checkOutput("holdValidA", 64'(readValidA), 64'h0);
        checkOutput("holdBusyA",  64'(readBusyA),  64'h2);

        // Reset arriving with a write to r4 and reads on both ports.
        applyStimulus(1'b1, 2'b01, 3'd4, 32'h99, 3'd0, 32'h0, 2'b11, 3'd4, 3'd4, 1'b0, 3'd0);
        checkOutput("midRstDataA",  64'(readDataA),   64'h0);
        checkOutput("midRstValidA", 64'(readValidA),  64'h0);
        checkOutput("midRstRBusyA", 64'(readBusyA),   64'h0);
        checkOutput("midRstBusyA",  64'(busyVectorA), 64'h0);
        checkOutput("midRstBusyB",  64'(busyVectorB), 64'h0);
        applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 2'b01, 3'd4, 3'd0, 1'b0, 3'd0);
        checkOutput("midRstR4A", 64'(readDataA),  64'h0);
        checkOutput("midRstR4B", 64'(readDataB),  64'h0);
        checkOutput("midRstR4V", 64'(readValidB), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
